flash_phy_rd_buf_array: RTL and testbench
=========================================

// Module: flash_phy_rd_buf_array
// PURPOSE
// - Parametrised array of NumBuf flash read buffers: tag + data storage with per-entry
//   state (Invalid/Wip/Valid) and associative lookup. Sits between the flash phy read
//   pipeline and the macro.
// - Performs victim selection (Invalid first, then LRU Valid; never Wip).
// - Supports address-matched wipe on program/erase and a global flush when disabled.
// PARAMETERS
// - NumBuf   4   number of buffer entries (>=2, power of 2)
// - AddrW    16  bank word address width
// - DataW    64  plain data width per entry
// - InfoSelW 2   info partition select width
// - IdxW     $clog2(NumBuf)  derived index width (localparam)
// PORTS
// - clk_i          in  1         clock
// - rst_ni         in  1         asynchronous reset, active-low
// - en_i           in  1         buffering enable; low flushes all entries
// - lkup_addr_i    in  AddrW     lookup address
// - lkup_part_i    in  1         lookup partition (data/info)
// - lkup_info_i    in  InfoSelW  lookup info select
// - lkup_req_i     in  1         lookup is live (qualifies LRU touch)
// - hit_o          out 1         a Valid entry matches the lookup tag
// - wip_hit_o      out 1         a Wip entry matches the lookup tag (caller must wait)
// - hit_idx_o      out IdxW      matching entry index
// - hit_data_o     out DataW     matching entry data
// - hit_err_o      out 1         matching entry error flag
// - alloc_i        in  1         allocate victim with lookup tag
// - alloc_ok_o     out 1         a non-Wip victim exists
// - alloc_idx_o    out IdxW      victim index (valid when alloc_ok_o)
// - upd_i          in  1         data return for entry upd_idx_i
// - upd_idx_i      in  IdxW      entry receiving data
// - upd_data_i     in  DataW     returned data
// - upd_err_i      in  1         returned error
// - wipe_i         in  1         invalidate entries matching wipe tag
// - wipe_addr_i    in  AddrW     wipe address (part/info use lkup_part_i/lkup_info_i)
// - attr_o         out 2*NumBuf  per-entry state vector, for debug/coverage
// BEHAVIOUR
// - Reset: all entries Invalid, data/addr/err 0, part=FlashPartData, info 0.
//   LRU age[i]=i. Outputs then: hit_o=0, wip_hit_o=0, alloc_ok_o=1, alloc_idx_o=0.
// - Entry FSM:
//   - Invalid->Wip on alloc. Tag latched; err cleared; data unchanged.
//   - Wip->Valid on upd. Data and err latched.
//   - Valid->Wip on alloc when selected as victim.
//   - Any state->Invalid on wipe match, or when en_i=0.
// - Lookup: combinational, 0-cycle.
//   - Tag match = addr, part and info all equal.
//   - hit_o considers Valid entries only; wip_hit_o considers Wip entries only.
//   - With no match, hit_idx_o/hit_data_o=0.
// - Victim: lowest-index Invalid entry; else the Valid entry with max age.
//   - alloc_ok_o=0 iff all entries are Wip. alloc_i while !alloc_ok_o is ignored.
// - LRU: age counters IdxW wide, always a permutation of 0..NumBuf-1.
//   - On alloc, or on lkup_req_i&hit_o: the touched entry's age becomes 0; every entry
//     younger than its old age increments.
//   - If alloc and hit occur in the same cycle, alloc touches; the hit touch is dropped.
//   - Invalidation does not change ages.
// - Priority per entry: !en_i > wipe > alloc > upd.
//   - wipe+upd on the same Wip entry: entry goes Invalid and the data is discarded.
//   - en_i=0: all entries Invalid next cycle; alloc/upd/wipe ignored; ages hold.
// - Updates take effect in the next cycle; a lookup in the update cycle still sees
//   the old state.
// - Reset mid-operation: all entries return to reset state; outstanding upd indexes
//   are meaningless, and the caller must drop them.
// - Assertions:
//   - upd_i&en_i -> entry[upd_idx_i] is Wip.
//   - At most one Valid/Wip entry matches any tag (onehot0).
//   - alloc_i -> !hit_o & !wip_hit_o.
//   - Ages form a permutation.
// STRUCTURE
// - flash_phy_pkg holds rd_buf_t and the rd_attr_e enum (Invalid/Wip/Valid).
//   Tag-match and victim functions are package functions.
// - Sub-module flash_phy_rd_buf_lru holds the age counters and victim select.
//   Entry storage and FSM are generate-loop flops in this module.
// TESTING
// - Reset, then alloc addr 0x10 -> idx 0 Wip, wip_hit_o=1.
//   Then upd idx0 data 0xA5 -> next cycle hit_o=1, hit_data_o=0xA5.
// - Fill 4 entries (0x10..0x13), hit 0x10, then alloc 0x20 -> victim idx1 (LRU),
//   not idx0.
// - 4 allocs with no upd -> alloc_ok_o=0; a 5th alloc_i changes nothing.
// - wipe 0x12 and upd on the same Wip entry in one cycle -> entry Invalid, hit_o=0
//   for 0x12.
// - en_i=0 for one cycle with 3 Valid entries -> all Invalid next cycle.
//   alloc_idx_o=0; ages unchanged.
// - upd_err_i=1 on idx2 -> hit_err_o=1 on lookup; re-alloc of idx2 clears err.

Source files
------------

// File: rtl/flash_phy_pkg.sv
// Shared types and helpers for the flash phy read buffer array.
// Buffer entry layout, entry state encoding, tag compare and victim/LRU helpers.
package flash_phy_pkg;

  localparam int unsigned RdBufNum      = 4;
  localparam int unsigned RdBufIdxW     = $clog2(RdBufNum);
  localparam int unsigned RdBufAddrW    = 16;
  localparam int unsigned RdBufDataW    = 64;
  localparam int unsigned RdBufInfoSelW = 2;

  typedef enum logic [1:0] {
    Invalid = 2'd0,
    Wip     = 2'd1,
    Valid   = 2'd2
  } rd_attr_e;

  typedef enum logic {
    FlashPartData = 1'b0,
    FlashPartInfo = 1'b1
  } flash_part_e;

  typedef struct packed {
    rd_attr_e                 attr;
    logic [RdBufAddrW-1:0]    addr;
    flash_part_e              part;
    logic [RdBufInfoSelW-1:0] info_sel;
    logic [RdBufDataW-1:0]    data;
    logic                     err;
  } rd_buf_t;

  localparam rd_buf_t RdBufReset = '{
    attr:     Invalid,
    addr:     '0,
    part:     FlashPartData,
    info_sel: '0,
    data:     '0,
    err:      1'b0
  };

  typedef logic [RdBufNum-1:0][RdBufIdxW-1:0] rd_age_t;

  typedef struct packed {
    logic                 ok;
    logic [RdBufIdxW-1:0] idx;
  } rd_victim_t;

  function automatic logic tag_match(input rd_buf_t                  b,
                                     input logic [RdBufAddrW-1:0]    addr,
                                     input flash_part_e              part,
                                     input logic [RdBufInfoSelW-1:0] info_sel);
    return (b.addr == addr) && (b.part == part) && (b.info_sel == info_sel);
  endfunction

  // Lowest-index Invalid entry wins; otherwise the oldest Valid entry. Wip is never chosen.
  function automatic rd_victim_t victim_sel(input logic [RdBufNum-1:0] invalid,
                                            input logic [RdBufNum-1:0] valid,
                                            input rd_age_t             age);
    rd_victim_t           v;
    logic                 found_inv;
    logic [RdBufIdxW-1:0] max_age;
    v         = '0;
    found_inv = 1'b0;
    max_age   = '0;
    for (int i = RdBufNum - 1; i >= 0; i--) begin
      if (invalid[i]) begin
        v.idx     = i[RdBufIdxW-1:0];
        found_inv = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int i = 0; i < RdBufNum; i++) begin
        if (valid[i] && (!v.ok || (age[i] > max_age))) begin
          v.ok    = 1'b1;
          v.idx   = i[RdBufIdxW-1:0];
          max_age = age[i];
        end
      end
    end
    v.ok = v.ok | found_inv;
    return v;
  endfunction

  function automatic logic ages_unique(input rd_age_t age);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < RdBufNum; i++) begin
      for (int j = i + 1; j < RdBufNum; j++) begin
        if (age[i] == age[j]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/flash_phy_rd_buf_lru.sv
// LRU age tracking and victim selection for the read buffer array.
// Ages update one cycle after a touch; victim output is combinational from current state.
module flash_phy_rd_buf_lru
  import flash_phy_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 touch_i,
  input  logic [RdBufIdxW-1:0] touch_idx_i,
  input  logic [RdBufNum-1:0]  invalid_i,
  input  logic [RdBufNum-1:0]  valid_i,
  output logic                 victim_ok_o,
  output logic [RdBufIdxW-1:0] victim_idx_o
);

  rd_age_t              age_q;
  rd_victim_t           victim;
  logic [RdBufIdxW-1:0] touch_age;

  assign touch_age = age_q[touch_idx_i];

  // Touched entry becomes youngest; only entries younger than it age, keeping a permutation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RdBufNum; i++) begin
        age_q[i] <= i[RdBufIdxW-1:0];
      end
    end else if (touch_i) begin
      for (int i = 0; i < RdBufNum; i++) begin
        if (i[RdBufIdxW-1:0] == touch_idx_i) begin
          age_q[i] <= '0;
        end else if (age_q[i] < touch_age) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  assign victim       = victim_sel(invalid_i, valid_i, age_q);
  assign victim_ok_o  = victim.ok;
  assign victim_idx_o = victim.idx;

`ifndef SYNTHESIS
  ages_perm_a: assert property (@(posedge clk_i) disable iff (!rst_ni) ages_unique(age_q));
`endif

endmodule

// File: rtl/flash_phy_rd_buf_array.sv
// Associative array of flash read buffers with Invalid/Wip/Valid entry state and LRU replacement.
// Lookup and victim outputs are combinational; alloc/upd/wipe/flush take effect next cycle.
module flash_phy_rd_buf_array
  import flash_phy_pkg::*;
#(
  parameter int unsigned NumBuf   = RdBufNum,
  parameter int unsigned AddrW    = RdBufAddrW,
  parameter int unsigned DataW    = RdBufDataW,
  parameter int unsigned InfoSelW = RdBufInfoSelW,
  localparam int unsigned IdxW    = $clog2(NumBuf)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [AddrW-1:0]    lkup_addr_i,
  input  logic                lkup_part_i,
  input  logic [InfoSelW-1:0] lkup_info_i,
  input  logic                lkup_req_i,
  output logic                hit_o,
  output logic                wip_hit_o,
  output logic [IdxW-1:0]     hit_idx_o,
  output logic [DataW-1:0]    hit_data_o,
  output logic                hit_err_o,
  input  logic                alloc_i,
  output logic                alloc_ok_o,
  output logic [IdxW-1:0]     alloc_idx_o,
  input  logic                upd_i,
  input  logic [IdxW-1:0]     upd_idx_i,
  input  logic [DataW-1:0]    upd_data_i,
  input  logic                upd_err_i,
  input  logic                wipe_i,
  input  logic [AddrW-1:0]    wipe_addr_i,
  output logic [2*NumBuf-1:0] attr_o
);

  // Entry layout and helpers live in the package, so widths are tied to its constants.
  if (NumBuf != RdBufNum || AddrW != RdBufAddrW || DataW != RdBufDataW ||
      InfoSelW != RdBufInfoSelW) begin : gen_param_chk
    $error("flash_phy_rd_buf_array parameters must match flash_phy_pkg constants");
  end

  rd_buf_t           bufs [NumBuf];
  logic [NumBuf-1:0] valid_vec, wip_vec, inv_vec;
  logic [NumBuf-1:0] lkup_match, wipe_match, hit_vec, wip_hit_vec, any_vec;
  flash_part_e       lkup_part;
  logic              alloc_fire, touch;
  logic [IdxW-1:0]   touch_idx;

  assign lkup_part = flash_part_e'(lkup_part_i);

  always_comb begin
    valid_vec  = '0;
    wip_vec    = '0;
    inv_vec    = '0;
    lkup_match = '0;
    wipe_match = '0;
    attr_o     = '0;
    for (int i = 0; i < NumBuf; i++) begin
      valid_vec[i]      = (bufs[i].attr == Valid);
      wip_vec[i]        = (bufs[i].attr == Wip);
      inv_vec[i]        = (bufs[i].attr == Invalid);
      lkup_match[i]     = tag_match(bufs[i], lkup_addr_i, lkup_part, lkup_info_i);
      wipe_match[i]     = tag_match(bufs[i], wipe_addr_i, lkup_part, lkup_info_i);
      attr_o[2*i +: 2]  = bufs[i].attr;
    end
  end

  assign hit_vec     = valid_vec & lkup_match;
  assign wip_hit_vec = wip_vec & lkup_match;
  assign any_vec     = hit_vec | wip_hit_vec;
  assign hit_o       = |hit_vec;
  assign wip_hit_o   = |wip_hit_vec;

  // At most one entry matches, so OR-ing the selected fields acts as a mux.
  always_comb begin
    hit_idx_o  = '0;
    hit_data_o = '0;
    hit_err_o  = 1'b0;
    for (int i = 0; i < NumBuf; i++) begin
      if (any_vec[i]) begin
        hit_idx_o  = hit_idx_o | i[IdxW-1:0];
        hit_data_o = hit_data_o | bufs[i].data;
        hit_err_o  = hit_err_o | bufs[i].err;
      end
    end
  end

  assign alloc_fire = en_i & alloc_i & alloc_ok_o;
  assign touch      = alloc_fire | (en_i & lkup_req_i & hit_o);
  assign touch_idx  = alloc_fire ? alloc_idx_o : hit_idx_o;

  flash_phy_rd_buf_lru u_lru (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .touch_i      (touch),
    .touch_idx_i  (touch_idx),
    .invalid_i    (inv_vec),
    .valid_i      (valid_vec),
    .victim_ok_o  (alloc_ok_o),
    .victim_idx_o (alloc_idx_o)
  );

  for (genvar i = 0; i < NumBuf; i++) begin : gen_entry
    rd_buf_t buf_q, buf_d;

    always_comb begin
      buf_d = buf_q;
      if (!en_i) begin
        buf_d.attr = Invalid;
      end else if (wipe_i && wipe_match[i]) begin
        buf_d.attr = Invalid;
      end else if (alloc_fire && (alloc_idx_o == IdxW'(i))) begin
        buf_d.attr     = Wip;
        buf_d.addr     = lkup_addr_i;
        buf_d.part     = lkup_part;
        buf_d.info_sel = lkup_info_i;
        buf_d.err      = 1'b0;
      end else if (upd_i && (upd_idx_i == IdxW'(i)) && (buf_q.attr == Wip)) begin
        buf_d.attr = Valid;
        buf_d.data = upd_data_i;
        buf_d.err  = upd_err_i;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        buf_q <= RdBufReset;
      end else begin
        buf_q <= buf_d;
      end
    end

    assign bufs[i] = buf_q;
  end

`ifndef SYNTHESIS
  upd_wip_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (upd_i && en_i) |-> (bufs[upd_idx_i].attr == Wip));
  lkup_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(any_vec));
  wipe_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(wipe_match & ~inv_vec));
  alloc_nomatch_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    alloc_i |-> (!hit_o && !wip_hit_o));
`endif

endmodule

// File: tb/tb_flash_phy_rd_buf_array.sv
// Directed bench for flash_phy_rd_buf_array: fill, LRU replacement, full-Wip, flush, wipe, error flag.
module tb_flash_phy_rd_buf_array;

  logic        clk_i, rst_ni, en_i;
  logic [15:0] lkup_addr_i;
  logic        lkup_part_i;
  logic [1:0]  lkup_info_i;
  logic        lkup_req_i;
  logic        hit_o, wip_hit_o, hit_err_o;
  logic [1:0]  hit_idx_o;
  logic [63:0] hit_data_o;
  logic        alloc_i, alloc_ok_o;
  logic [1:0]  alloc_idx_o;
  logic        upd_i;
  logic [1:0]  upd_idx_i;
  logic [63:0] upd_data_i;
  logic        upd_err_i;
  logic        wipe_i;
  logic [15:0] wipe_addr_i;
  logic [7:0]  attr_o;

  int checks = 0;
  int errors = 0;

  flash_phy_rd_buf_array dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .lkup_addr_i (lkup_addr_i),
    .lkup_part_i (lkup_part_i),
    .lkup_info_i (lkup_info_i),
    .lkup_req_i  (lkup_req_i),
    .hit_o       (hit_o),
    .wip_hit_o   (wip_hit_o),
    .hit_idx_o   (hit_idx_o),
    .hit_data_o  (hit_data_o),
    .hit_err_o   (hit_err_o),
    .alloc_i     (alloc_i),
    .alloc_ok_o  (alloc_ok_o),
    .alloc_idx_o (alloc_idx_o),
    .upd_i       (upd_i),
    .upd_idx_i   (upd_idx_i),
    .upd_data_i  (upd_data_i),
    .upd_err_i   (upd_err_i),
    .wipe_i      (wipe_i),
    .wipe_addr_i (wipe_addr_i),
    .attr_o      (attr_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    alloc_i    = 1'b0;
    upd_i      = 1'b0;
    upd_err_i  = 1'b0;
    wipe_i     = 1'b0;
    lkup_req_i = 1'b0;
  endtask

  task automatic do_alloc(input logic [15:0] addr);
    lkup_addr_i = addr;
    alloc_i     = 1'b1;
  endtask

  task automatic do_upd(input logic [1:0] idx, input logic [63:0] data, input logic err);
    upd_i      = 1'b1;
    upd_idx_i  = idx;
    upd_data_i = data;
    upd_err_i  = err;
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b1; idle();
    lkup_addr_i = '0; lkup_part_i = 1'b0; lkup_info_i = '0;
    upd_idx_i = '0; upd_data_i = '0; wipe_addr_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    chk("rst_hit",       64'(hit_o),       64'd0);
    chk("rst_wip_hit",   64'(wip_hit_o),   64'd0);
    chk("rst_alloc_ok",  64'(alloc_ok_o),  64'd1);
    chk("rst_alloc_idx", 64'(alloc_idx_o), 64'd0);
    chk("rst_attr",      64'(attr_o),      64'h00);

    // Allocate 0x10, then return data.
    do_alloc(16'h10); #1;
    chk("t1_alloc_idx", 64'(alloc_idx_o), 64'd0);
    tick(); idle(); #1;
    chk("t1_wip_hit",  64'(wip_hit_o), 64'd1);
    chk("t1_hit_wip",  64'(hit_o),     64'd0);
    chk("t1_wip_idx",  64'(hit_idx_o), 64'd0);
    chk("t1_attr",     64'(attr_o),    64'h01);
    do_upd(2'd0, 64'hA5, 1'b0); #1;
    chk("t1_hit_upd_cycle", 64'(hit_o), 64'd0);
    tick(); idle(); #1;
    chk("t1_hit",      64'(hit_o),      64'd1);
    chk("t1_hit_data", hit_data_o,      64'hA5);
    chk("t1_hit_err",  64'(hit_err_o),  64'd0);
    chk("t1_wip_gone", 64'(wip_hit_o),  64'd0);

    // Fill remaining entries, touch 0x10, LRU victim must be idx1.
    do_alloc(16'h11); #1;
    chk("t2_alloc_idx1", 64'(alloc_idx_o), 64'd1);
    tick(); idle();
    do_alloc(16'h12); do_upd(2'd1, 64'h11, 1'b0); #1;
    chk("t2_alloc_idx2", 64'(alloc_idx_o), 64'd2);
    tick(); idle();
    do_alloc(16'h13); do_upd(2'd2, 64'h12, 1'b0); #1;
    chk("t2_alloc_idx3", 64'(alloc_idx_o), 64'd3);
    tick(); idle();
    lkup_addr_i = 16'h10; lkup_req_i = 1'b1; do_upd(2'd3, 64'h13, 1'b0); #1;
    chk("t2_hit10",     64'(hit_o),     64'd1);
    chk("t2_hit10_idx", 64'(hit_idx_o), 64'd0);
    tick(); idle();
    lkup_addr_i = 16'h20; #1;
    chk("t2_miss20",     64'(hit_o),       64'd0);
    chk("t2_lru_victim", 64'(alloc_idx_o), 64'd1);
    alloc_i = 1'b1;
    tick(); idle(); #1;
    chk("t2_wip20",     64'(wip_hit_o), 64'd1);
    chk("t2_wip20_idx", 64'(hit_idx_o), 64'd1);
    chk("t2_attr",      64'(attr_o),    64'hA6);
    lkup_addr_i = 16'h13; #1;
    chk("t2_data13",    hit_data_o,     64'h13);

    // Three more allocs without data: every entry Wip.
    do_alloc(16'h21); #1;
    chk("t3_victim_a", 64'(alloc_idx_o), 64'd2);
    tick(); idle();
    do_alloc(16'h22); #1;
    chk("t3_victim_b", 64'(alloc_idx_o), 64'd3);
    tick(); idle();
    do_alloc(16'h23); #1;
    chk("t3_victim_c", 64'(alloc_idx_o), 64'd0);
    tick(); idle(); #1;
    chk("t3_alloc_ok_full", 64'(alloc_ok_o), 64'd0);
    chk("t3_attr_all_wip",  64'(attr_o),     64'h55);
    do_alloc(16'h24);
    tick(); idle(); #1;
    chk("t3_ignored_attr", 64'(attr_o),    64'h55);
    chk("t3_ignored_tag",  64'(wip_hit_o), 64'd0);
    lkup_addr_i = 16'h21; #1;
    chk("t3_wip21_idx",    64'(hit_idx_o), 64'd2);
    do_upd(2'd0, 64'h23, 1'b0);
    tick(); idle(); #1;
    chk("t3_alloc_ok_back", 64'(alloc_ok_o),  64'd1);
    chk("t3_victim_valid",  64'(alloc_idx_o), 64'd0);
    do_upd(2'd1, 64'h20, 1'b0);
    tick(); idle();
    do_upd(2'd2, 64'h21, 1'b0);
    tick(); idle();
    lkup_addr_i = 16'h20; #1;
    chk("t3_data20", hit_data_o, 64'h20);

    // Flush with three Valid entries; concurrent alloc/upd ignored.
    en_i = 1'b0; do_alloc(16'h50); do_upd(2'd3, 64'h99, 1'b0);
    tick(); en_i = 1'b1; idle(); #1;
    chk("t5_attr_flushed", 64'(attr_o),      64'h00);
    chk("t5_alloc_idx",    64'(alloc_idx_o), 64'd0);
    chk("t5_alloc_ok",     64'(alloc_ok_o),  64'd1);
    lkup_addr_i = 16'h20; #1;
    chk("t5_hit20_gone",   64'(hit_o),       64'd0);
    lkup_addr_i = 16'h22; #1;
    chk("t5_wip22_gone",   64'(wip_hit_o),   64'd0);

    // Wipe with info mismatch keeps entry; wipe + upd same cycle drops it.
    do_alloc(16'h12); #1;
    chk("t4_alloc_idx", 64'(alloc_idx_o), 64'd0);
    tick(); idle();
    lkup_info_i = 2'd1; wipe_i = 1'b1; wipe_addr_i = 16'h12; #1;
    chk("t4_info_miss", 64'(wip_hit_o), 64'd0);
    tick(); idle(); lkup_info_i = 2'd0; #1;
    chk("t4_wipe_info_kept", 64'(wip_hit_o), 64'd1);
    wipe_i = 1'b1; wipe_addr_i = 16'h12; do_upd(2'd0, 64'h77, 1'b0);
    tick(); idle(); #1;
    chk("t4_wipe_hit",  64'(hit_o),     64'd0);
    chk("t4_wipe_wip",  64'(wip_hit_o), 64'd0);
    chk("t4_wipe_attr", 64'(attr_o),    64'h00);

    // Error flag on idx2, then re-alloc of idx2 clears it.
    do_alloc(16'h30); #1;
    chk("t6_alloc0", 64'(alloc_idx_o), 64'd0);
    tick(); idle();
    do_alloc(16'h31); do_upd(2'd0, 64'h30, 1'b0); #1;
    chk("t6_alloc1", 64'(alloc_idx_o), 64'd1);
    tick(); idle();
    do_alloc(16'h32); do_upd(2'd1, 64'h31, 1'b0); #1;
    chk("t6_alloc2", 64'(alloc_idx_o), 64'd2);
    tick(); idle();
    do_alloc(16'h33); do_upd(2'd2, 64'hBEEF, 1'b1); #1;
    chk("t6_alloc3", 64'(alloc_idx_o), 64'd3);
    tick(); idle();
    do_upd(2'd3, 64'h33, 1'b0);
    tick(); idle();
    lkup_addr_i = 16'h32; #1;
    chk("t6_hit32",      64'(hit_o),     64'd1);
    chk("t6_hit32_idx",  64'(hit_idx_o), 64'd2);
    chk("t6_hit32_err",  64'(hit_err_o), 64'd1);
    chk("t6_hit32_data", hit_data_o,     64'hBEEF);
    lkup_addr_i = 16'h31; #1;
    chk("t6_hit31_err",  64'(hit_err_o), 64'd0);
    chk("t6_hit31_data", hit_data_o,     64'h31);
    lkup_addr_i = 16'h30; lkup_req_i = 1'b1;
    tick(); lkup_addr_i = 16'h31;
    tick(); lkup_addr_i = 16'h33;
    tick(); idle();
    lkup_addr_i = 16'h40; #1;
    chk("t6_victim2", 64'(alloc_idx_o), 64'd2);
    alloc_i = 1'b1;
    tick(); idle(); #1;
    chk("t6_realloc_wip",  64'(wip_hit_o),  64'd1);
    chk("t6_realloc_idx",  64'(hit_idx_o),  64'd2);
    chk("t6_realloc_err",  64'(hit_err_o),  64'd0);
    chk("t6_realloc_data", hit_data_o,      64'hBEEF);
    do_upd(2'd2, 64'h40, 1'b0);
    tick(); idle(); #1;
    chk("t6_hit40",      64'(hit_o),  64'd1);
    chk("t6_hit40_data", hit_data_o,  64'h40);

    // Asynchronous reset mid-operation.
    rst_ni = 1'b0; #1;
    chk("rst_async_attr",  64'(attr_o),      64'h00);
    chk("rst_async_alloc", 64'(alloc_idx_o), 64'd0);
    chk("rst_async_hit",   64'(hit_o),       64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
